// File: rtl/if_id_stage.sv
// Fetch PC register and IF/ID pipeline register for the five-stage MIPS core.
// Define IF_EXC_EN to enable the fetch address-error (AdEL) check.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc,
  input  logic        flush_d,
  input  logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc8D,
  output logic        validD,
  output logic [4:0]  exccodeD
);

`ifdef IF_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  // One bit wider so a memory ending exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_END   = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic        fetch_fault;
  logic [31:0] instr_load;
  logic [4:0]  exc_load;

  always_comb begin
    fetch_fault = EXC_EN && ((pcF[1:0] != 2'b00) ||
                             (pcF < IM_BASE) ||
                             ({1'b0, pcF} >= IM_END));
    instr_load  = fetch_fault ? '0 : instrF;
    exc_load    = fetch_fault ? EXC_ADEL : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)        pcF <= PC_RESET;
    else if (stall)   pcF <= pcF;
    else if (npc_sel) pcF <= npc;
    else              pcF <= pcF + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      instrD   <= '0;
      pcD      <= '0;
      validD   <= 1'b0;
      exccodeD <= '0;
    end else if (!stall) begin
      instrD   <= instr_load;
      pcD      <= pcF;
      validD   <= 1'b1;
      exccodeD <= exc_load;
    end
  end

  assign pc8D = pcD + 32'd8;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-stage program counter plus IF/ID pipeline register for the five-stage MIPS core. It holds the fetch PC, drives it to the instruction memory, and advances it by 4 or redirects it to a next-PC resolved in decode. It latches the fetched instruction and its PC into the IF/ID register, which feeds the decode-stage field splitter and control. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, fetch PC after reset
- IM_BASE, 32'h0000_3000, first byte address of instruction memory
- IM_WORDS, 4096, instruction memory depth in 32-bit words

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold the PC and the IF/ID register
- npc_sel  in  1  decode has resolved a taken branch or jump; take npc
- npc  in  32  redirect target from decode
- flush_d  in  1  load a bubble into IF/ID
- instrF  in  32  instruction word read from IM at pcF (combinational)
- pcF  out  32  current fetch PC, goes to IM address
- instrD  out  32  latched instruction, goes to the decode field splitter
- pcD  out  32  PC of instrD
- pc8D  out  32  pcD + 8, the link value for jal/jalr
- validD  out  1  IF/ID holds a real instruction, not a bubble
- exccodeD  out  5  fetch exception code for instrD; 0 means none

## Operation
- PC register update priority: reset, then stall, then npc_sel, then sequential.
  - reset: pcF <= PC_RESET.
  - stall: pcF holds. npc_sel and npc are ignored. Decode must keep asserting npc_sel for every cycle its branch is stalled.
  - npc_sel with no stall: pcF <= npc.
  - Otherwise: pcF <= pcF + 4, 32-bit and wrapping modulo 2^32.
- IF/ID register update priority: reset, then flush_d, then stall, then load.
  - reset or flush_d: instrD <= 0, pcD <= 0, validD <= 0, exccodeD <= 0.
  - stall: all IF/ID outputs hold.
  - load: instrD <= instrF (or the fetch-exception substitute), pcD <= pcF, validD <= 1, exccodeD <= fetch code.
- flush_d does not affect the PC. If flush_d and stall are both asserted, IF/ID takes the bubble and the PC holds.
- Branch delay slots are architectural. npc_sel never squashes the instruction in IF, so the slot instruction enters IF/ID normally.
- pc8D is combinational from pcD and equals pcD + 8, wrapping.
- The PC path contains no other state. No instruction is dropped or duplicated across any sequence of stall, npc_sel and flush_d.

## Timing
- Reset values: pcF = PC_RESET, instrD = 0, pcD = 0, pc8D = 8, validD = 0, exccodeD = 0.
- The first instruction is at PC_RESET. It appears on instrD one cycle after reset deasserts.
- Fetch-to-decode latency is 1 cycle.
- A redirect takes effect at the next edge: with npc_sel asserted in cycle n, pcF = npc in cycle n+1. The delay-slot instruction is fetched in cycle n and appears on instrD in cycle n+1.
- Reset asserted mid-stream overrides stall, flush_d and npc_sel in the same cycle.
- A stall lasting k cycles holds pcF and instrD unchanged for exactly k cycles.

## Configuration
- IF_EXC_EN defined:
  - A fetch is faulting when pcF[1:0] != 0, when pcF < IM_BASE, or when pcF >= IM_BASE + 4*IM_WORDS.
  - On a faulting load: instrD <= 0 (a nop), exccodeD <= 5'd4 (AdEL), validD <= 1, pcD <= the faulting pcF.
  - The PC continues to advance normally; the exception handler redirects it.
- IF_EXC_EN undefined:
  - No check is performed and instrF is latched unconditionally.
  - The exccodeD port still exists and is constant 0.

## Test plan
- Reset, then 4 free-running cycles: pcF = 0x3000, 0x3004, 0x3008, 0x300C. instrD lags instrF by 1 cycle. validD goes 0 then 1. pc8D = pcD + 8.
- Redirect: npc_sel=1, npc=0x3100 while pcF=0x3008. pcF becomes 0x3100 next cycle. The 0x3008 instruction (delay slot) still reaches instrD with pcD=0x3008.
- Stall for 3 cycles with npc_sel held at 1, npc=0x3200: pcF and instrD are frozen for 3 cycles. pcF = 0x3200 on the cycle after stall drops.
- flush_d and stall asserted together at pcF=0x3010: instrD=0, validD=0 next cycle. pcF stays 0x3010.
- IF_EXC_EN defined, npc=0x3002: next IF/ID load gives instrD=0, exccodeD=4, pcD=0x3002, validD=1. Repeat with npc=0x0000_2FFC and with npc = IM_BASE + 4*IM_WORDS; both give exccodeD=4. With the macro undefined, exccodeD stays 0 in all three cases.
- Reset asserted during a stall with npc_sel=1: next cycle pcF=0x3000, validD=0.
